pll_reset_sequencer: RTL and testbench

//  Sequences the system PLL: pulses the PLL reset, waits for a filtered lock with timeout/retry, then

---
 rtl/pll_seq_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/pll_reset_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared types and constants for the PLL reset sequencer
package pll_seq_pkg;

    typedef enum logic [2:0] {
        S_PLLRST,
        S_WAITLOCK,
        S_FILTER,
        S_RELEASE,
        S_RUN,
        S_FAIL
    } state_e;

    localparam int RETRY_W = 4;
    localparam int LOSS_W  = 8;

    // Width of a down-counter able to hold the largest of the timing parameters.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous bit
// Ports: clk_i clock, rst_i async active-high reset (output clears to 0),
//        d_i asynchronous input, q_o synchronized output (2-edge latency).
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset pulse, filtered lock wait with retry, staggered domain release
// Ports: refclk free-running clock; rst async active-high reset; pll_locked async lock input;
//        sw_reset level re-sequence request; pll_rst PLL reset; rst_out per-domain resets (bit 0 first);
//        ready all domains out of reset; fail retries exhausted; retry_cnt timeouts (sat 15);
//        loss_cnt lock-loss events in run (sat 255).
// Build option: LOCK_LOSS_COUNT_EN enables loss_cnt; otherwise loss_cnt is tied to zero.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int LOCK_FILTER    = 64,
    parameter int NUM_DOMAINS    = 3,
    parameter int STAGGER        = 8,
    parameter int MAX_RETRIES    = 4
) (
    input  logic                   refclk,
    input  logic                   rst,
    input  logic                   pll_locked,
    input  logic                   sw_reset,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] rst_out,
    output logic                   ready,
    output logic                   fail,
    output logic [RETRY_W-1:0]     retry_cnt,
    output logic [LOSS_W-1:0]      loss_cnt
);

    localparam int CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_FILTER, STAGGER);
    localparam logic [CNT_W-1:0] PRST_LD = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LD  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FILT_LD = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] STAG_LD = CNT_W'(STAGGER - 1);

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       tmo_q;
    logic                   pll_rst_q;
    logic [NUM_DOMAINS-1:0] rst_out_q;
    logic                   ready_q;
    logic                   fail_q;
    logic [RETRY_W-1:0]     retry_q;
    logic                   lk;

    logic [NUM_DOMAINS-1:0] mask_shift_d;
    logic [CNT_W-1:0]       stagger_ld_d;
    logic [CNT_W-1:0]       tmo_dec_d;
    logic [RETRY_W-1:0]     retry_inc_d;
    logic                   retry_fail_d;

    sync_2ff u_lock_sync (
        .clk_i (refclk),
        .rst_i (rst),
        .d_i   (pll_locked),
        .q_o   (lk)
    );

    // Releasing a domain shifts a zero in from bit 0, so bits clear in index order.
    // The load after clearing the last bit is 0 so RUN follows on the very next edge.
    assign mask_shift_d = rst_out_q << 1;
    assign stagger_ld_d = (mask_shift_d == '0) ? '0 : STAG_LD;
    assign tmo_dec_d    = (tmo_q == '0) ? '0 : tmo_q - CNT_W'(1);
    assign retry_inc_d  = (retry_q == '1) ? retry_q : retry_q + RETRY_W'(1);
    assign retry_fail_d = (MAX_RETRIES != 0) && ((int'(retry_q) + 1) == MAX_RETRIES);

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= S_PLLRST;
            cnt_q     <= PRST_LD;
            tmo_q     <= '0;
            pll_rst_q <= 1'b1;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
            retry_q   <= '0;
        end else if (sw_reset) begin
            state_q   <= S_PLLRST;
            cnt_q     <= PRST_LD;
            pll_rst_q <= 1'b1;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
            retry_q   <= '0;
        end else begin
            case (state_q)
                S_PLLRST: begin
                    if (cnt_q == '0) begin
                        state_q   <= S_WAITLOCK;
                        pll_rst_q <= 1'b0;
                        tmo_q     <= TMO_LD;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                // The lock timeout keeps running across WAITLOCK and FILTER; a lock
                // that completes filtering on the timeout cycle still wins.
                S_WAITLOCK, S_FILTER: begin
                    tmo_q <= tmo_dec_d;
                    if (!lk && state_q == S_FILTER) begin
                        state_q <= S_WAITLOCK;
                    end else if (lk && state_q == S_WAITLOCK) begin
                        state_q <= S_FILTER;
                        cnt_q   <= FILT_LD;
                    end else if (lk && cnt_q == '0) begin
                        state_q   <= S_RELEASE;
                        rst_out_q <= mask_shift_d;
                        cnt_q     <= stagger_ld_d;
                    end else if (tmo_q == '0) begin
                        retry_q   <= retry_inc_d;
                        pll_rst_q <= 1'b1;
                        cnt_q     <= PRST_LD;
                        if (retry_fail_d) begin
                            state_q <= S_FAIL;
                            fail_q  <= 1'b1;
                        end else begin
                            state_q <= S_PLLRST;
                        end
                    end else begin
                        // cnt_q is meaningless in WAITLOCK, so decrementing it there is harmless
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_RELEASE: begin
                    if (!lk) begin
                        state_q   <= S_PLLRST;
                        pll_rst_q <= 1'b1;
                        rst_out_q <= '1;
                        cnt_q     <= PRST_LD;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (rst_out_q == '0) begin
                        state_q <= S_RUN;
                        ready_q <= 1'b1;
                    end else begin
                        rst_out_q <= mask_shift_d;
                        cnt_q     <= stagger_ld_d;
                    end
                end
                S_RUN: begin
                    if (!lk) begin
                        state_q   <= S_PLLRST;
                        pll_rst_q <= 1'b1;
                        rst_out_q <= '1;
                        ready_q   <= 1'b0;
                        cnt_q     <= PRST_LD;
                    end
                end
                S_FAIL: begin
                    state_q <= S_FAIL;
                end
                default: begin
                    state_q   <= S_PLLRST;
                    pll_rst_q <= 1'b1;
                    rst_out_q <= '1;
                    ready_q   <= 1'b0;
                    cnt_q     <= PRST_LD;
                end
            endcase
        end
    end

`ifdef LOCK_LOSS_COUNT_EN
    logic [LOSS_W-1:0] loss_q;

    // Mirrors the RUN lock-loss branch; a simultaneous sw_reset takes priority and is not counted.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            loss_q <= '0;
        end else if (!sw_reset && state_q == S_RUN && !lk && loss_q != '1) begin
            loss_q <= loss_q + LOSS_W'(1);
        end
    end

    assign loss_cnt = loss_q;
`else
    assign loss_cnt = '0;
`endif

    assign pll_rst   = pll_rst_q;
    assign rst_out   = rst_out_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - directed/randomized self-checking bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

    localparam int PRC = 16;
    localparam int TMO = 400;
    localparam int FLT = 64;
    localparam int ND  = 3;
    localparam int STG = 8;
    localparam int MR  = 4;

    logic          refclk = 1'b0;
    logic          rst = 1'b1;
    logic          pll_locked = 1'b0;
    logic          sw_reset = 1'b0;
    logic          pll_rst;
    logic [ND-1:0] rst_out;
    logic          ready;
    logic          fail;
    logic [3:0]    retry_cnt;
    logic [7:0]    loss_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int losses   = 0;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES (PRC),
        .LOCK_TIMEOUT   (TMO),
        .LOCK_FILTER    (FLT),
        .NUM_DOMAINS    (ND),
        .STAGGER        (STG),
        .MAX_RETRIES    (MR)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .sw_reset   (sw_reset),
        .pll_rst    (pll_rst),
        .rst_out    (rst_out),
        .ready      (ready),
        .fail       (fail),
        .retry_cnt  (retry_cnt),
        .loss_cnt   (loss_cnt)
    );

    always #5 refclk = ~refclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge refclk);
        #1;
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int loss_model();
`ifdef LOCK_LOSS_COUNT_EN
        return losses;
`else
        return 0;
`endif
    endfunction

    // Edge on which rst_out[0] clears: lock is seen by the FSM 3 edges after pll_locked rises
    // (2 sync flops + decision edge), but no earlier than the first edge after WAITLOCK entry;
    // it must then hold for LOCK_FILTER further edges.
    function automatic int rel_cyc(input int w, input int k);
        int start;
        start = (w + 1 > k + 3) ? w + 1 : k + 3;
        return start + FLT;
    endfunction

    function automatic bit cond(input int sel);
        case (sel)
            0:       return rst_out[0] == 1'b0;
            1:       return rst_out[1] == 1'b0;
            2:       return rst_out[2] == 1'b0;
            3:       return ready == 1'b1;
            4:       return pll_rst == 1'b0;
            5:       return pll_rst == 1'b1;
            6:       return rst_out == 3'b111;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_cond(input int sel, input int bound);
        int n;
        n = 0;
        while (!cond(sel) && n < bound) begin
            step();
            n++;
        end
    endtask

    task automatic check_release(input int t0);
        wait_cond(0, 2000);
        chk("bit0_cyc", cyc, t0);
        chk("bit0_mask", rst_out, 3'b110);
        chk("bit0_ready", ready, 1'b0);
        wait_cond(1, 2000);
        chk("bit1_cyc", cyc, t0 + STG);
        chk("bit1_mask", rst_out, 3'b100);
        wait_cond(2, 2000);
        chk("bit2_cyc", cyc, t0 + 2 * STG);
        chk("bit2_ready", ready, 1'b0);
        wait_cond(3, 2000);
        chk("ready_cyc", cyc, t0 + 2 * STG + 1);
        chk("ready_mask", rst_out, 3'b000);
        chk("ready_pllrst", pll_rst, 1'b0);
    endtask

    initial begin
        int c0, w, k, k1, k2, kg, s0, s1, s2, d, g, j, sbase;

        // reset values
        steps(3);
        chk("rst_pllrst", pll_rst, 1'b1);
        chk("rst_rstout", rst_out, 3'b111);
        chk("rst_ready", ready, 1'b0);
        chk("rst_fail", fail, 1'b0);
        chk("rst_retry", retry_cnt, 4'd0);
        chk("rst_loss", loss_cnt, 8'd0);
        rst = 1'b0;
        c0 = cyc;

        // 1: normal bring-up with a random lock delay
        wait_cond(4, 2000);
        chk("t1_pllrst_width", cyc - c0, PRC);
        w = cyc;
        d = $urandom_range(20, 200);
        steps(d);
        k = cyc;
        pll_locked = 1'b1;
        check_release(rel_cyc(w, k));

        // 3: one-cycle lock glitch in RUN
        steps($urandom_range(1, 20));
        k = cyc;
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        losses++;
        wait_cond(6, 50);
        chk("t3_loss_latency", cyc - k, 3);
        chk("t3_ready", ready, 1'b0);
        chk("t3_pllrst", pll_rst, 1'b1);
        chk("t3_loss", loss_cnt, loss_model());
        wait_cond(4, 2000);
        chk("t3_pllrst_fall", cyc, k + 3 + PRC);
        w = cyc;
        check_release(rel_cyc(w, k + 1));

        // 4: sustained loss, then a 5-cycle glitch inside the filter window
        steps($urandom_range(1, 20));
        k = cyc;
        pll_locked = 1'b0;
        losses++;
        wait_cond(6, 50);
        chk("t4_loss_latency", cyc - k, 3);
        chk("t4_loss", loss_cnt, loss_model());
        wait_cond(4, 2000);
        chk("t4_pllrst_fall", cyc, k + 3 + PRC);
        w = cyc;
        d = $urandom_range(10, 60);
        steps(d);
        k1 = cyc;
        pll_locked = 1'b1;
        g = $urandom_range(5, 40);
        steps(3 + g);
        kg = cyc;
        pll_locked = 1'b0;
        steps(5);
        k2 = cyc;
        pll_locked = 1'b1;
        chk("t4_glitch_mask", rst_out, 3'b111);
        check_release(rel_cyc(w, k2));
        chk("t4_retry", retry_cnt, 4'd0);
        chk("t4_kg_order", (kg > k1) ? 1 : 0, 1);

        // 5a: sw_reset in RUN, then again mid-release
        steps($urandom_range(1, 10));
        s0 = cyc;
        sw_reset = 1'b1;
        step();
        sw_reset = 1'b0;
        chk("t5_run_rstout", rst_out, 3'b111);
        chk("t5_run_pllrst", pll_rst, 1'b1);
        chk("t5_run_ready", ready, 1'b0);
        chk("t5_run_loss", loss_cnt, loss_model());
        wait_cond(4, 2000);
        chk("t5_run_fall", cyc, s0 + 1 + PRC);
        w = cyc;
        wait_cond(0, 2000);
        chk("t5_bit0_cyc", cyc, rel_cyc(w, 0));
        j = $urandom_range(1, 6);
        steps(j);
        s1 = cyc;
        sw_reset = 1'b1;
        pll_locked = 1'b0;
        step();
        sw_reset = 1'b0;
        chk("t5_rel_rstout", rst_out, 3'b111);
        chk("t5_rel_pllrst", pll_rst, 1'b1);
        chk("t5_rel_ready", ready, 1'b0);
        chk("t5_rel_retry", retry_cnt, 4'd0);

        // 2: no lock ever -> MR pulses, then FAIL
        sbase = s1 + 1;
        for (int i = 1; i <= MR; i++) begin
            wait_cond(4, 2000);
            chk("t2_fall_cyc", cyc, sbase + (i - 1) * (PRC + TMO) + PRC);
            w = cyc;
            wait_cond(5, 2000);
            chk("t2_timeout_cyc", cyc, w + TMO);
            chk("t2_retry", retry_cnt, i);
            chk("t2_fail", fail, (i == MR) ? 1 : 0);
        end
        steps(300);
        chk("t2_hold_pllrst", pll_rst, 1'b1);
        chk("t2_hold_fail", fail, 1'b1);
        chk("t2_hold_rstout", rst_out, 3'b111);
        chk("t2_hold_retry", retry_cnt, MR);

        // 5b: sw_reset out of FAIL
        s2 = cyc;
        sw_reset = 1'b1;
        step();
        sw_reset = 1'b0;
        chk("t5f_fail", fail, 1'b0);
        chk("t5f_retry", retry_cnt, 4'd0);
        chk("t5f_pllrst", pll_rst, 1'b1);
        chk("t5f_rstout", rst_out, 3'b111);
        chk("t5f_loss", loss_cnt, loss_model());
        wait_cond(4, 2000);
        chk("t5f_fall", cyc, s2 + 1 + PRC);
        w = cyc;

        // 6: asynchronous rst mid-release
        steps(5);
        k = cyc;
        pll_locked = 1'b1;
        wait_cond(0, 2000);
        chk("t6_bit0_cyc", cyc, rel_cyc(w, k));
        steps(2);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_pllrst", pll_rst, 1'b1);
        chk("t6_rstout", rst_out, 3'b111);
        chk("t6_ready", ready, 1'b0);
        chk("t6_fail", fail, 1'b0);
        chk("t6_retry", retry_cnt, 4'd0);
        chk("t6_loss", loss_cnt, 8'd0);
        steps(2);
        rst = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
